// File: rtl/bfp_normalizer.sv
// Block floating-point normalizer: buffers BLOCK_LEN complex samples, then replays them left-shifted by the block exponent.
// Latency: first output one cycle after the BLOCK_LEN-th input transfer; one sample per cycle in each phase.
// Backpressure: o_ready is high only while filling; outputs hold while o_valid && !i_ready.
module bfp_normalizer #(
  parameter int WIDTH     = 16,
  parameter int BLOCK_LEN = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_re,
  input  logic [WIDTH-1:0] i_im,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_re,
  output logic [WIDTH-1:0] o_im,
  output logic [4:0]       o_shift,
  output logic             o_last
);

  localparam logic ST_FILL  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  localparam int             AW       = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [AW-1:0]  LAST_IDX = AW'(BLOCK_LEN - 1);
  localparam logic [4:0]     MAX_CNT  = 5'(WIDTH - 1);

  logic             state;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [4:0]       min_cnt;
  logic [WIDTH-1:0] buf_re [BLOCK_LEN];
  logic [WIDTH-1:0] buf_im [BLOCK_LEN];

  logic             in_xfer;
  logic             out_xfer;
  logic [4:0]       cnt_re;
  logic [4:0]       cnt_im;
  logic [4:0]       smp_min;
  logic [4:0]       blk_min;

  // Number of bits below the sign bit that match it: the largest left shift
  // that cannot change the sign or lose magnitude.
  function automatic logic [4:0] lead_cnt(input logic [WIDTH-1:0] x);
    logic [4:0] n;
    logic       run;
    n   = '0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH-1])) n = n + 5'd1;
      else                             run = 1'b0;
    end
    return n;
  endfunction

  assign o_ready  = (state == ST_FILL);
  assign o_valid  = (state == ST_DRAIN);
  assign o_last   = (state == ST_DRAIN) && (rd_idx == LAST_IDX);
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;

  // Shift is the minimum headroom over the whole block, so no sample overflows.
  assign o_re = buf_re[rd_idx] << o_shift;
  assign o_im = buf_im[rd_idx] << o_shift;

  // Headroom of the incoming sample folded into the block minimum; the first
  // sample of a block re-seeds the minimum instead of folding into it.
  always_comb begin
    cnt_re  = lead_cnt(i_re);
    cnt_im  = lead_cnt(i_im);
    smp_min = (cnt_re < cnt_im) ? cnt_re : cnt_im;
    blk_min = smp_min;
    if ((wr_idx != '0) && (min_cnt < smp_min)) blk_min = min_cnt;
  end

  // Sample storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      buf_re[wr_idx] <= i_re;
      buf_im[wr_idx] <= i_im;
    end
  end

  // FILL/DRAIN sequencing, indices, running minimum and block exponent.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_FILL;
      wr_idx  <= '0;
      rd_idx  <= '0;
      min_cnt <= MAX_CNT;
      o_shift <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (in_xfer) begin
            min_cnt <= blk_min;
            if (wr_idx == LAST_IDX) begin
              o_shift <= blk_min;
              wr_idx  <= '0;
              state   <= ST_DRAIN;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        default: begin
          if (out_xfer) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              state  <= ST_FILL;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bfp_normalizer.sv
// Directed table of blocks plus reset corner cases and a randomized
// gap/backpressure run against a range-based exponent model.
module tb_bfp_normalizer;
  localparam int W = 16;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_re;
  logic [W-1:0] i_im;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_re;
  logic [W-1:0] o_im;
  logic [4:0]   o_shift;
  logic         o_last;

  always #5 clk = ~clk;

  bfp_normalizer #(.WIDTH(W), .BLOCK_LEN(N)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_re(i_re), .i_im(i_im), .o_valid(o_valid), .i_ready(i_ready),
    .o_re(o_re), .o_im(o_im), .o_shift(o_shift), .o_last(o_last)
  );

  typedef struct {
    logic [15:0] b_re;
    logic [15:0] b_im;
    int          sp;
    logic [15:0] s_re;
    logic [15:0] s_im;
    logic [4:0]  shift;
  } vec_t;

  vec_t        tbl [8];
  logic [15:0] blk_re [N];
  logic [15:0] blk_im [N];
  logic [4:0]  last_shift;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Largest shift that keeps x*2^s inside the signed 16-bit range.
  function automatic int headroom(input logic [15:0] x);
    logic signed [15:0] xs;
    int v;
    int s;
    xs = x;
    v  = xs;
    s  = 0;
    while (s < 15 && (v * (2 ** (s + 1))) >= -32768 && (v * (2 ** (s + 1))) <= 32767) s++;
    return s;
  endfunction

  function automatic logic [4:0] ref_shift();
    int best;
    best = 15;
    for (int k = 0; k < N; k++) begin
      if (headroom(blk_re[k]) < best) best = headroom(blk_re[k]);
      if (headroom(blk_im[k]) < best) best = headroom(blk_im[k]);
    end
    return 5'(best);
  endfunction

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < N; k++) begin
      blk_re[k] = (k == v.sp) ? v.s_re : v.b_re;
      blk_im[k] = (k == v.sp) ? v.s_im : v.b_im;
    end
  endtask

  task automatic send_block(input bit gaps, input string tag);
    for (int k = 0; k < N; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          i_valid = 1'b0;
          @(negedge clk);
          chk({tag, "_gap_ready"}, o_ready, 1);
        end
      end
      i_valid = 1'b1;
      i_re    = blk_re[k];
      i_im    = blk_im[k];
      chk({tag, "_fill_ready"}, o_ready, 1);
      chk({tag, "_fill_valid"}, o_valid, 0);
      chk({tag, "_fill_shift_hold"}, o_shift, last_shift);
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  task automatic drain_block(input logic [4:0] exp_shift, input bit bp, input string tag);
    chk({tag, "_latency_valid"}, o_valid, 1);
    for (int k = 0; k < N; k++) begin
      logic [15:0] er;
      logic [15:0] ei;
      bit          done;
      int          cyc;
      er   = blk_re[k] << exp_shift;
      ei   = blk_im[k] << exp_shift;
      done = 1'b0;
      cyc  = 0;
      while (!done) begin
        i_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        chk({tag, "_valid"}, o_valid, 1);
        chk({tag, "_ready_low"}, o_ready, 0);
        chk($sformatf("%s_re[%0d]", tag, k), o_re, er);
        chk($sformatf("%s_im[%0d]", tag, k), o_im, ei);
        chk($sformatf("%s_sign_re[%0d]", tag, k), o_re[15], blk_re[k][15]);
        chk($sformatf("%s_sign_im[%0d]", tag, k), o_im[15], blk_im[k][15]);
        chk({tag, "_shift"}, o_shift, exp_shift);
        chk($sformatf("%s_last[%0d]", tag, k), o_last, (k == N - 1));
        done = o_valid && i_ready;
        @(negedge clk);
        cyc++;
        if (!done && cyc > 100) begin
          total++;
          bad++;
          $display("FAIL %s_drain_timeout: sample %0d never accepted within 100 cycles", tag, k);
          done = 1'b1;
        end
      end
    end
    i_ready = 1'b0;
    chk({tag, "_ready_after"}, o_ready, 1);
    chk({tag, "_valid_after"}, o_valid, 0);
    chk({tag, "_shift_after"}, o_shift, exp_shift);
    last_shift = exp_shift;
  endtask

  initial begin
    tbl[0] = '{16'h0010, 16'h0010, -1, 16'h0000, 16'h0000, 5'd10};
    tbl[1] = '{16'h0000, 16'h0000,  5, 16'hFF00, 16'h0000, 5'd7};
    tbl[2] = '{16'h1234, 16'h0567,  3, 16'h1234, 16'h8000, 5'd0};
    tbl[3] = '{16'h0000, 16'h0000, -1, 16'h0000, 16'h0000, 5'd15};
    tbl[4] = '{16'h4000, 16'h4000, -1, 16'h0000, 16'h0000, 5'd0};
    tbl[5] = '{16'h0100, 16'h0100, -1, 16'h0000, 16'h0000, 5'd6};
    tbl[6] = '{16'h0003, 16'hFFFC, 15, 16'h0020, 16'hFFFC, 5'd9};
    tbl[7] = '{16'hFFFF, 16'h0000,  0, 16'hFFFF, 16'h0001, 5'd14};

    rstn       = 1'b0;
    i_valid    = 1'b0;
    i_ready    = 1'b0;
    i_re       = '0;
    i_im       = '0;
    last_shift = 5'd0;
    repeat (2) @(negedge clk);
    chk("reset_ready", o_ready, 1);
    chk("reset_valid", o_valid, 0);
    chk("reset_last", o_last, 0);
    chk("reset_shift", o_shift, 0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      load_vec(tbl[i]);
      send_block(i % 2 == 1, $sformatf("vec%0d", i));
      drain_block(tbl[i].shift, i % 2 == 1, $sformatf("vec%0d", i));
    end

    // Reset after 9 inputs: the partial block must be discarded.
    for (int k = 0; k < 9; k++) begin
      i_valid = 1'b1;
      i_re    = 16'h7000;
      i_im    = 16'h7000;
      @(negedge clk);
    end
    i_valid = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    chk("rst_fill_ready", o_ready, 1);
    chk("rst_fill_valid", o_valid, 0);
    chk("rst_fill_shift", o_shift, 0);
    rstn       = 1'b1;
    last_shift = 5'd0;
    load_vec(tbl[5]);
    send_block(1'b0, "post_rst_fill");
    drain_block(5'd6, 1'b0, "post_rst_fill");

    // Reset mid-drain: output stops and the next block starts clean.
    load_vec(tbl[0]);
    send_block(1'b0, "pre_rst_drain");
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    i_ready = 1'b0;
    rstn    = 1'b0;
    @(negedge clk);
    chk("rst_drain_valid", o_valid, 0);
    chk("rst_drain_ready", o_ready, 1);
    chk("rst_drain_last", o_last, 0);
    rstn       = 1'b1;
    last_shift = 5'd0;
    load_vec(tbl[1]);
    send_block(1'b0, "post_rst_drain");
    drain_block(5'd7, 1'b0, "post_rst_drain");

    // Randomized blocks with input gaps and output backpressure.
    for (int b = 0; b < 50; b++) begin
      int amt;
      amt = $urandom_range(0, 15);
      for (int k = 0; k < N; k++) begin
        logic signed [15:0] t;
        t = 16'($urandom);
        blk_re[k] = t >>> amt;
        t = 16'($urandom);
        blk_im[k] = t >>> amt;
      end
      send_block(1'b1, "rand");
      drain_block(ref_shift(), 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
